// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped BTB with optional 2-bit saturating direction counters.
//   IF looks up pc_in combinationally to choose next_pc; EX writes back one
//   resolved control instruction per cycle and gets mispredict/recover_pc.
//   Branch and mispredict counts are kept and saturate at all-ones.
//
// Ports
//   Clk, Reset_N               clock (posedge), async active-low reset
//   pc_in                      IF-stage PC to look up
//   pred_taken, pred_target    prediction for pc_in (target 0 on miss)
//   next_pc                    pred_taken ? pred_target : pc_in+1
//   upd_valid, upd_is_branch   EX resolves a branch (1) or jump (0)
//   upd_pc, upd_taken, upd_target              resolved outcome
//   upd_pred_taken, upd_pred_target            prediction made in IF
//   mispredict, recover_pc     EX redirect information
//   num_branches, num_mispredicts              saturating statistics
//
// Parameters
//   WORD_SIZE   PC/target/statistic width
//   INDEX_BITS  log2 of BTB entries; index = PC[INDEX_BITS-1:0]
//   MODE        0 never taken, 1 taken on BTB hit, 2 hit and counter[1]
module branch_predictor #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 4,
  parameter int MODE       = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic [WORD_SIZE-1:0] next_pc,
  input  logic                 upd_valid,
  input  logic                 upd_is_branch,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_pred_taken,
  input  logic [WORD_SIZE-1:0] upd_pred_target,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] recover_pc,
  output logic [WORD_SIZE-1:0] num_branches,
  output logic [WORD_SIZE-1:0] num_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] look_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  look_hit;
  logic                  upd_hit;

  assign look_idx = pc_in[INDEX_BITS-1:0];
  assign upd_idx  = upd_pc[INDEX_BITS-1:0];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == pc_in[WORD_SIZE-1:INDEX_BITS]);
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_pc[WORD_SIZE-1:INDEX_BITS]);

  // Lookup reads the registered table only, so an update to the same index
  // in this cycle is not bypassed and becomes visible one cycle later.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = look_hit ? target_q[look_idx] : '0;
    if (MODE == 1) begin
      pred_taken = look_hit;
    end else if (MODE == 2) begin
      pred_taken = look_hit && ctr_q[look_idx][1];
    end
    next_pc = pred_taken ? pred_target : pc_in + WORD_SIZE'(1);
  end

  // A taken instruction is mispredicted if the direction differs or the
  // predicted target was wrong; a not-taken one only on direction.
  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
  assign recover_pc = upd_taken ? upd_target : upd_pc + WORD_SIZE'(1);

  // Table maintenance is independent of MODE so modes can be swapped freely.
  // Not-taken misses are not allocated: they would only predict fall-through.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_is_branch) begin
          if (upd_taken) begin
            target_q[upd_idx] <= upd_target;
            if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
          end else if (ctr_q[upd_idx] != 2'b00) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
          end
        end else begin
          target_q[upd_idx] <= upd_target;
          ctr_q[upd_idx]    <= 2'b11;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_pc[WORD_SIZE-1:INDEX_BITS];
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= upd_is_branch ? 2'b10 : 2'b11;
      end
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      num_branches    <= '0;
      num_mispredicts <= '0;
    end else begin
      if (upd_valid && (num_branches != '1)) begin
        num_branches <= num_branches + WORD_SIZE'(1);
      end
      if (mispredict && (num_mispredicts != '1)) begin
        num_mispredicts <= num_mispredicts + WORD_SIZE'(1);
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch predictor for the 5-stage pipelined datapath; replaces the fixed always-taken PC+imm adder in IF.
- IF performs a combinational lookup to produce next PC.
- EX resolves branches and jumps, then drives one update per cycle.
- The block computes mispredict and recovery PC, and keeps branch and mispredict statistics.

Parameters:
- WORD_SIZE, 16, PC, target and counter width.
- INDEX_BITS, 4, BTB entries = 2^INDEX_BITS, direct-mapped, index = PC[INDEX_BITS-1:0].
- MODE, 2, prediction mode: 0 always-not-taken, 1 always-taken on BTB hit, 2 two-bit saturating counter.

Ports:
- Clk  input  1  clock, posedge.
- Reset_N  input  1  asynchronous active-low reset.
- pc_in  input  WORD_SIZE  IF-stage PC to look up.
- pred_taken  output  1  prediction for pc_in (combinational).
- pred_target  output  WORD_SIZE  BTB target for pc_in; 0 on miss.
- next_pc  output  WORD_SIZE  pred_taken ? pred_target : pc_in+1.
- upd_valid  input  1  EX resolves a control instruction this cycle (ignore for bubbles).
- upd_is_branch  input  1  1 = conditional branch, 0 = unconditional jump.
- upd_pc  input  WORD_SIZE  PC of the resolved instruction.
- upd_taken  input  1  actual direction.
- upd_target  input  WORD_SIZE  actual target.
- upd_pred_taken  input  1  prediction carried down the pipeline with the instruction.
- upd_pred_target  input  WORD_SIZE  predicted target carried down the pipeline.
- mispredict  output  1  combinational, qualified by upd_valid.
- recover_pc  output  WORD_SIZE  upd_taken ? upd_target : upd_pc+1.
- num_branches  output  WORD_SIZE  count of upd_valid cycles, saturating.
- num_mispredicts  output  WORD_SIZE  count of mispredict cycles, saturating.

Behaviour:
- Reset (async, Reset_N=0):
  - all entry valid bits=0, tags and targets=0, counters=2'b01;
  - num_branches=0, num_mispredicts=0;
  - outputs then follow from the table state: pred_taken=0, pred_target=0, next_pc=pc_in+1, mispredict=0 while upd_valid=0.
  - Reset mid-operation discards all table state immediately, with no clock needed.
- Entry fields: valid, tag = PC[WORD_SIZE-1:INDEX_BITS], target, 2-bit counter. hit = valid && tag match.
- Lookup is zero latency (combinational on pc_in):
  - MODE 0: pred_taken=0.
  - MODE 1: pred_taken=hit.
  - MODE 2: pred_taken = hit && counter[1].
  - pred_target = hit ? target : 0.
- mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
- Update is written at posedge Clk when upd_valid=1, indexed by upd_pc:
  - Hit, conditional branch: counter increments if taken, decrements if not, saturating at 3 and 0. Target is overwritten only when taken.
  - Hit, jump: counter=2'b11, target overwritten.
  - Miss, taken: allocate the entry (overwrite any prior occupant). valid=1, tag and target from the update. counter = 2'b10 for a branch, 2'b11 for a jump.
  - Miss, not-taken: no allocation and no change to the table.
  - MODE 0: the table is still maintained, so the mode can be switched by recompile without changing update logic.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns pre-update contents; the new value is visible the next cycle. No bypass.
- Statistics:
  - num_branches += 1 per upd_valid cycle.
  - num_mispredicts += 1 per mispredict cycle.
  - Both hold at all-ones; no wrap.
- Arithmetic: pc_in+1 and upd_pc+1 are modulo 2^WORD_SIZE, so 16'hFFFF+1 = 0.

Test Plan:
1. Reset, then pc_in=16'h0010 -> pred_taken=0, next_pc=16'h0011, both counters 0. Assert Reset_N mid-clock after training -> valid cleared before the next edge.
2. MODE 2, branch at 16'h0020 to target 16'h0008:
   - update taken, pred 0 -> mispredict=1, recover_pc=16'h0008, allocate with counter=2.
   - next lookup at 16'h0020 -> pred_taken=1, next_pc=16'h0008.
   - update not-taken, pred 1 -> mispredict=1, recover_pc=16'h0021, counter=1.
   - next lookup -> pred_taken=0.
3. Aliasing with INDEX_BITS=4: train 16'h0023 taken, then lookup 16'h0033 -> miss, pred_taken=0. Taken update at 16'h0033 evicts 16'h0023, so 16'h0023 now misses.
4. Jump at 16'h0040 to 16'h0100, then 3 not-taken updates as branch -> counter 3→0, saturating at 0. Lookup -> pred_taken=0 in MODE 2, 1 in MODE 1.
5. Same-cycle lookup and update of 16'h0050 -> lookup shows miss that cycle, hit next cycle. Correct prediction (pred 1, target match) -> mispredict=0, num_branches increments, num_mispredicts unchanged.
6. Drive 70000 mispredicting updates -> both counters stick at 16'hFFFF. upd_pc=16'hFFFF not-taken -> recover_pc=16'h0000.
